// File: rtl/qdi2bin_pkg.sv
// Shared types and helpers for the e1ofM -> binary receiver.
package qdi2bin_pkg;

   typedef enum logic {
      S_NEUTRAL,
      S_IDLE
   } state_t;

   localparam int ERRCNT_W = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/qdi2bin_fifo.sv
// Synchronous FIFO with registered full/empty/level; head word read straight
// from storage so a pop exposes the next entry with no extra latency.
module qdi2bin_fifo
   import qdi2bin_pkg::*;
#(
   parameter int W     = 4,
   parameter int DEPTH = 4,
   localparam int AW   = clog2(DEPTH),
   localparam int LW   = clog2(DEPTH + 1)
)(
   input  logic          CLK,
   input  logic          RESET,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;
   logic [LW-1:0] level_d;

   // Accept only against registered flags: a full FIFO refuses a push even
   // when a pop happens in the same cycle.
   always_comb begin
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      level_d = level;
      if (push_ok && !pop_ok)      level_d = level + LW'(1);
      else if (pop_ok && !push_ok) level_d = level - LW'(1);
   end

   // Storage, pointers and registered occupancy flags.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (pop_ok)
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         level <= level_d;
         full  <= (level_d == LW'(DEPTH));
         empty <= (level_d == '0);
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/qdi2bin_rx_1ofm.sv
// Multi-digit e1ofM QDI receiver: rail synchroniser, completion/neutral
// detection, one-hot decode with invalid-code flagging, handshake FSM and
// an output FIFO. Optional macro QDI2BIN_ERRCNT_EN adds a saturating
// err_count output.
module qdi2bin_rx_1ofm
   import qdi2bin_pkg::*;
#(
   parameter int DIGITS      = 2,
   parameter int RADIX       = 4,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   localparam int DW         = clog2(RADIX),
   localparam int W          = DIGITS * DW,
   localparam int LW         = clog2(DEPTH + 1),
   localparam int NR         = DIGITS * RADIX
)(
   input  logic                CLK,
   input  logic                RESET,
   input  logic [NR-1:0]       L,
   output logic                Le,
   output logic [W-1:0]        dout,
   output logic                valid,
   input  logic                ready,
   output logic [LW-1:0]       level,
`ifdef QDI2BIN_ERRCNT_EN
   output logic [ERRCNT_W-1:0] err_count,
`endif
   output logic                err
);

   logic [NR-1:0]          sync_q [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] busy_q;
   logic [NR-1:0]          Ls;
   logic                   complete, neutral, bad, push, full, empty;
   logic [W-1:0]           word;
   state_t                 state_q, state_d;

   // Per-rail synchroniser, cleared by reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= L;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Synchronised "any rail high" that keeps running through reset, so a
   // freshly cleared synchroniser is not mistaken for a neutral channel.
   always_ff @(posedge CLK) begin
      busy_q <= {busy_q[SYNC_STAGES-2:0], |L};
   end

   assign Ls = sync_q[SYNC_STAGES-1];

   // Completion, neutrality and per-digit decode (multi-hot -> 0, flagged).
   always_comb begin
      logic [RADIX-1:0] dig;
      logic [DW-1:0]    val;
      complete = 1'b1;
      bad      = 1'b0;
      word     = '0;
      neutral  = (Ls == '0) && (busy_q == '0);
      for (int unsigned d = 0; d < DIGITS; d++) begin
         dig = Ls[d*RADIX +: RADIX];
         val = '0;
         if (dig == '0)
            complete = 1'b0;
         else if (!$onehot(dig))
            bad = 1'b1;
         else
            for (int unsigned i = 0; i < RADIX; i++)
               if (dig[i]) val = DW'(i);
         word[d*DW +: DW] = val;
      end
   end

   // Handshake next-state: capture a complete token when there is room.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         S_NEUTRAL: if (neutral) state_d = S_IDLE;
         S_IDLE: begin
            if (complete && !full) begin
               push    = 1'b1;
               state_d = S_NEUTRAL;
            end
         end
         default: state_d = S_NEUTRAL;
      endcase
   end

   // State register with registered Le and err outputs.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= S_NEUTRAL;
         Le      <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         Le      <= (state_d == S_IDLE);
         err     <= push && bad;
      end
   end

`ifdef QDI2BIN_ERRCNT_EN
   // Saturating count of invalid-code captures.
   always_ff @(posedge CLK) begin
      if (!RESET)
         err_count <= '0;
      else if (err && (err_count != '1))
         err_count <= err_count + ERRCNT_W'(1);
   end
`endif

   qdi2bin_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (push),
      .pop   (ready),
      .din   (word),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign valid = ~empty;

endmodule
